// File: rtl/rupt_priority.sv
// Priority interrupt controller: latches one-cycle request pulses, presents the
// highest-priority pending source to the sequence generator and tracks the handshake.
module rupt_priority #(
    parameter int          NSRC      = 10,
    parameter logic [11:0] RUPT_BASE = 12'o4000
) (
    input  logic            CLOCK,
    input  logic            rst,
    input  logic [NSRC-1:0] RUPTREQ,
    input  logic            INHINT,
    input  logic            MNHRPT,
    input  logic            IIP,
    input  logic            KRPT,
    input  logic            RSM3,
    input  logic            GOJAM,
    output logic            RUPTOR_,
    output logic [11:0]     RPTADR,
    output logic [3:0]      RPTNUM,
    output logic [NSRC-1:0] PENDING,
    output logic            BUSY
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_ACKD, S_SERVE} state_e;

    localparam logic [3:0] NONE = 4'd15;

    state_e          state_q;
    logic [NSRC-1:0] pending_q;
    logic [NSRC-1:0] pending_d;
    logic [NSRC-1:0] clr_mask;
    logic [3:0]      tmo_q;
    logic [3:0]      rptnum_q;
    logic [11:0]     rptadr_q;
    logic            ruptor_n_q;
    logic            busy_q;
    logic [3:0]      sel_idx;
    logic            inhibit;

    function automatic logic [11:0] vec_addr(input logic [3:0] n);
        if (n == NONE) return 12'o0000;
        return RUPT_BASE + {6'd0, n, 2'b00} + 12'd4;
    endfunction

    assign inhibit = INHINT | MNHRPT;

    // Lowest-index pending bit wins; the descending loop lets it overwrite higher ones.
    always_comb begin
        sel_idx = NONE;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (pending_q[i]) sel_idx = 4'(i);
        end
    end

    // A request arriving in the acknowledge cycle is OR-ed in after the clear, so it survives.
    always_comb begin
        clr_mask  = '0;
        if (state_q == S_REQ && KRPT) clr_mask = NSRC'(1) << sel_idx;
        pending_d = (pending_q & ~clr_mask) | RUPTREQ;
    end

    // NOTE: every register, including the pending latches, is reset here; the bank is tiny
    // and an unknown pending bit would raise a spurious interrupt after power-up.
    always_ff @(posedge CLOCK or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pending_q  <= '0;
            tmo_q      <= '0;
            rptnum_q   <= NONE;
            rptadr_q   <= 12'o0000;
            ruptor_n_q <= 1'b1;
            busy_q     <= 1'b0;
        end else if (GOJAM) begin
            state_q    <= S_IDLE;
            pending_q  <= '0;
            tmo_q      <= '0;
            rptnum_q   <= NONE;
            rptadr_q   <= 12'o0000;
            ruptor_n_q <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            unique case (state_q)
                S_IDLE: begin
                    if (pending_q != '0 && !inhibit && !IIP) begin
                        state_q    <= S_REQ;
                        ruptor_n_q <= 1'b0;
                        rptnum_q   <= sel_idx;
                        rptadr_q   <= vec_addr(sel_idx);
                    end
                end
                S_REQ: begin
                    if (KRPT) begin
                        state_q    <= S_ACKD;
                        ruptor_n_q <= 1'b1;
                        busy_q     <= 1'b1;
                        tmo_q      <= '0;
                        rptnum_q   <= sel_idx;
                        rptadr_q   <= vec_addr(sel_idx);
                    end else if (inhibit) begin
                        state_q    <= S_IDLE;
                        ruptor_n_q <= 1'b1;
                        rptnum_q   <= NONE;
                        rptadr_q   <= 12'o0000;
                    end else begin
                        rptnum_q   <= sel_idx;
                        rptadr_q   <= vec_addr(sel_idx);
                    end
                end
                S_ACKD: begin
                    if (IIP) begin
                        state_q <= S_SERVE;
                    end else if (tmo_q == 4'd15) begin
                        state_q  <= S_IDLE;
                        busy_q   <= 1'b0;
                        rptnum_q <= NONE;
                        rptadr_q <= 12'o0000;
                    end else begin
                        tmo_q <= tmo_q + 4'd1;
                    end
                end
                S_SERVE: begin
                    if (RSM3) begin
                        state_q  <= S_IDLE;
                        busy_q   <= 1'b0;
                        rptnum_q <= NONE;
                        rptadr_q <= 12'o0000;
                    end
                end
                default: begin
                    state_q    <= S_IDLE;
                    ruptor_n_q <= 1'b1;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign RUPTOR_ = ruptor_n_q;
    assign RPTNUM  = rptnum_q;
    assign RPTADR  = rptadr_q;
    assign PENDING = pending_q;
    assign BUSY    = busy_q;

endmodule

// File: tb/tb_rupt_priority.sv
// Bench for rupt_priority: directed handshake scenarios plus a randomized run
// compared every cycle against a cycle-level behavioural model.
module tb_rupt_priority;

    logic        CLOCK = 1'b0;
    logic        rst;
    logic [9:0]  RUPTREQ;
    logic        INHINT, MNHRPT, IIP, KRPT, RSM3, GOJAM;
    logic        RUPTOR_;
    logic [11:0] RPTADR;
    logic [3:0]  RPTNUM;
    logic [9:0]  PENDING;
    logic        BUSY;

    int checks   = 0;
    int failures = 0;

    rupt_priority #(.NSRC(10), .RUPT_BASE(12'o4000)) dut (
        .CLOCK(CLOCK), .rst(rst), .RUPTREQ(RUPTREQ), .INHINT(INHINT), .MNHRPT(MNHRPT),
        .IIP(IIP), .KRPT(KRPT), .RSM3(RSM3), .GOJAM(GOJAM), .RUPTOR_(RUPTOR_),
        .RPTADR(RPTADR), .RPTNUM(RPTNUM), .PENDING(PENDING), .BUSY(BUSY)
    );

    always #5 CLOCK = ~CLOCK;

    // Behavioural model: phase of the handshake, latched requests, shown source, ack age.
    localparam int M_IDLE = 0, M_ASKING = 1, M_TAKEN = 2, M_SERVICE = 3;
    logic [9:0] m_pend;
    int         m_phase;
    int         m_shown;
    int         m_age;

    function automatic int lowest_set(input logic [9:0] v);
        for (int i = 0; i < 10; i++) if (v[i]) return i;
        return 15;
    endfunction

    function automatic logic [11:0] addr_of(input int n);
        if (n == 15) return 12'd0;
        return 12'(2048 + 4 * (n + 1));
    endfunction

    task automatic model_reset();
        m_pend = '0; m_phase = M_IDLE; m_shown = 15; m_age = 0;
    endtask

    task automatic model_step();
        int         top;
        logic [9:0] taken;
        top   = lowest_set(m_pend);
        taken = '0;
        if (GOJAM) begin
            model_reset();
            return;
        end
        case (m_phase)
            M_IDLE:
                if (m_pend != 0 && !INHINT && !MNHRPT && !IIP) begin
                    m_phase = M_ASKING; m_shown = top;
                end
            M_ASKING:
                if (KRPT) begin
                    taken[top] = 1'b1; m_shown = top; m_phase = M_TAKEN; m_age = 0;
                end else if (INHINT || MNHRPT) begin
                    m_phase = M_IDLE; m_shown = 15;
                end else begin
                    m_shown = top;
                end
            M_TAKEN: begin
                m_age++;
                if (IIP) m_phase = M_SERVICE;
                else if (m_age >= 16) begin m_phase = M_IDLE; m_shown = 15; end
            end
            default:
                if (RSM3) begin m_phase = M_IDLE; m_shown = 15; end
        endcase
        m_pend = (m_pend & ~taken) | RUPTREQ;
    endtask

    task automatic tick(input logic [9:0] req, input logic krpt, input logic rsm3, input logic gojam);
        RUPTREQ = req; KRPT = krpt; RSM3 = rsm3; GOJAM = gojam;
        @(posedge CLOCK);
        model_step();
        #1;
        RUPTREQ = '0; KRPT = 1'b0; RSM3 = 1'b0; GOJAM = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; RUPTREQ = '0; INHINT = 0; MNHRPT = 0; IIP = 0; KRPT = 0; RSM3 = 0; GOJAM = 0;
        model_reset();
        repeat (2) @(posedge CLOCK);
        #1 rst = 1'b0;
        checks++; if (RUPTOR_ !== 1'b1) begin failures++; $display("FAIL reset_ruptor got=%b exp=1", RUPTOR_); end
        checks++; if (RPTNUM !== 4'd15) begin failures++; $display("FAIL reset_rptnum got=%0d exp=15", RPTNUM); end
        checks++; if (RPTADR !== 12'd0) begin failures++; $display("FAIL reset_rptadr got=%o exp=0", RPTADR); end
        checks++; if (PENDING !== 10'd0) begin failures++; $display("FAIL reset_pending got=%h exp=0", PENDING); end
        checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", BUSY); end
    endtask

    task automatic test_single();
        tick(10'h010, 0, 0, 0);
        checks++; if (RUPTOR_ !== 1'b1 || PENDING !== 10'h010) begin failures++; $display("FAIL single_latch ruptor=%b pend=%h exp 1/010", RUPTOR_, PENDING); end
        tick('0, 0, 0, 0);
        checks++; if (RUPTOR_ !== 1'b0) begin failures++; $display("FAIL single_ruptor got=%b exp=0", RUPTOR_); end
        checks++; if (RPTNUM !== 4'd4 || RPTADR !== 12'o4024) begin failures++; $display("FAIL single_vec got=%0d/%o exp=4/4024", RPTNUM, RPTADR); end
        tick('0, 1, 0, 0);
        checks++; if (PENDING !== 10'h000 || BUSY !== 1'b1) begin failures++; $display("FAIL single_ack pend=%h busy=%b exp 000/1", PENDING, BUSY); end
        tick('0, 1, 0, 0);
        checks++; if (BUSY !== 1'b1 || RPTNUM !== 4'd4 || RUPTOR_ !== 1'b1) begin failures++; $display("FAIL single_stray_krpt busy=%b num=%0d ruptor=%b exp 1/4/1", BUSY, RPTNUM, RUPTOR_); end
        tick('0, 0, 0, 1);
    endtask

    task automatic test_priority();
        tick(10'h204, 0, 0, 0);
        tick('0, 0, 0, 0);
        checks++; if (RPTNUM !== 4'd2 || RPTADR !== 12'o4014) begin failures++; $display("FAIL prio_first got=%0d/%o exp=2/4014", RPTNUM, RPTADR); end
        tick('0, 1, 0, 0);
        IIP = 1'b1;
        tick('0, 0, 0, 0);
        IIP = 1'b0;
        tick('0, 0, 1, 0);
        checks++; if (BUSY !== 1'b0 || PENDING !== 10'h200) begin failures++; $display("FAIL prio_resume busy=%b pend=%h exp 0/200", BUSY, PENDING); end
        tick('0, 0, 0, 0);
        checks++; if (RPTNUM !== 4'd9 || RPTADR !== 12'o4050 || RUPTOR_ !== 1'b0) begin failures++; $display("FAIL prio_second got=%0d/%o/%b exp=9/4050/0", RPTNUM, RPTADR, RUPTOR_); end
        tick(10'h002, 0, 0, 0);
        checks++; if (RPTNUM !== 4'd9) begin failures++; $display("FAIL preempt_lag got=%0d exp=9", RPTNUM); end
        tick('0, 0, 0, 0);
        checks++; if (RPTNUM !== 4'd1 || RPTADR !== 12'o4010) begin failures++; $display("FAIL preempt_new got=%0d/%o exp=1/4010", RPTNUM, RPTADR); end
        tick('0, 1, 0, 0);
        checks++; if (PENDING !== 10'h200 || RPTNUM !== 4'd1) begin failures++; $display("FAIL preempt_ack pend=%h num=%0d exp 200/1", PENDING, RPTNUM); end
        tick('0, 0, 0, 1);
    endtask

    task automatic test_inhibit();
        INHINT = 1'b1;
        tick(10'h001, 0, 0, 0);
        tick('0, 0, 0, 0);
        tick('0, 0, 0, 0);
        checks++; if (RUPTOR_ !== 1'b1 || PENDING !== 10'h001) begin failures++; $display("FAIL inh_hold ruptor=%b pend=%h exp 1/001", RUPTOR_, PENDING); end
        INHINT = 1'b0;
        tick('0, 0, 0, 0);
        checks++; if (RUPTOR_ !== 1'b0 || RPTADR !== 12'o4004) begin failures++; $display("FAIL inh_release ruptor=%b adr=%o exp 0/4004", RUPTOR_, RPTADR); end
        MNHRPT = 1'b1;
        tick('0, 0, 0, 0);
        checks++; if (RUPTOR_ !== 1'b1 || PENDING !== 10'h001 || RPTNUM !== 4'd15) begin failures++; $display("FAIL mnh_drop ruptor=%b pend=%h num=%0d exp 1/001/15", RUPTOR_, PENDING, RPTNUM); end
        MNHRPT = 1'b0;
        tick('0, 0, 0, 0);
        checks++; if (RUPTOR_ !== 1'b0 || RPTNUM !== 4'd0) begin failures++; $display("FAIL mnh_release ruptor=%b num=%0d exp 0/0", RUPTOR_, RPTNUM); end
        tick('0, 0, 0, 1);
    endtask

    task automatic test_same_bit();
        tick(10'h008, 0, 0, 0);
        tick('0, 0, 0, 0);
        tick(10'h008, 1, 0, 0);
        checks++; if (PENDING !== 10'h008 || BUSY !== 1'b1) begin failures++; $display("FAIL same_bit pend=%h busy=%b exp 008/1", PENDING, BUSY); end
        IIP = 1'b1;
        tick('0, 0, 0, 0);
        checks++; if (RUPTOR_ !== 1'b1) begin failures++; $display("FAIL no_nest ruptor=%b exp 1", RUPTOR_); end
        IIP = 1'b0;
        tick('0, 0, 1, 0);
        tick('0, 0, 0, 0);
        checks++; if (RUPTOR_ !== 1'b0 || RPTNUM !== 4'd3) begin failures++; $display("FAIL same_bit_again ruptor=%b num=%0d exp 0/3", RUPTOR_, RPTNUM); end
        tick('0, 0, 0, 1);
    endtask

    task automatic test_timeout();
        tick(10'h040, 0, 0, 0);
        tick('0, 0, 0, 0);
        tick('0, 1, 0, 0);
        repeat (15) tick('0, 0, 1, 0);
        checks++; if (BUSY !== 1'b1) begin failures++; $display("FAIL tmo_early busy=%b exp 1", BUSY); end
        tick('0, 0, 0, 0);
        checks++; if (BUSY !== 1'b0 || RPTNUM !== 4'd15 || RPTADR !== 12'd0) begin failures++; $display("FAIL tmo_exit busy=%b num=%0d adr=%o exp 0/15/0", BUSY, RPTNUM, RPTADR); end
        tick('0, 0, 0, 0);
        checks++; if (PENDING !== 10'h000 || RUPTOR_ !== 1'b1) begin failures++; $display("FAIL tmo_cleared pend=%h ruptor=%b exp 000/1", PENDING, RUPTOR_); end
    endtask

    task automatic reach_serve_full();
        tick(10'h3FF, 0, 0, 0);
        tick('0, 0, 0, 0);
        tick('0, 1, 0, 0);
        IIP = 1'b1;
        tick(10'h3FF, 0, 0, 0);
    endtask

    task automatic test_gojam();
        reach_serve_full();
        checks++; if (PENDING !== 10'h3FF || BUSY !== 1'b1) begin failures++; $display("FAIL gojam_setup pend=%h busy=%b exp 3ff/1", PENDING, BUSY); end
        tick(10'h3FF, 0, 0, 1);
        checks++; if (PENDING !== 10'h000 || RUPTOR_ !== 1'b1 || RPTNUM !== 4'd15 || BUSY !== 1'b0) begin failures++; $display("FAIL gojam pend=%h ruptor=%b num=%0d busy=%b exp 000/1/15/0", PENDING, RUPTOR_, RPTNUM, BUSY); end
        IIP = 1'b0;
    endtask

    task automatic test_rst_mid();
        reach_serve_full();
        #2 rst = 1'b1;
        #1;
        checks++; if (PENDING !== 10'h000 || RUPTOR_ !== 1'b1 || RPTNUM !== 4'd15 || RPTADR !== 12'd0 || BUSY !== 1'b0) begin failures++; $display("FAIL rst_mid pend=%h ruptor=%b num=%0d adr=%o busy=%b", PENDING, RUPTOR_, RPTNUM, RPTADR, BUSY); end
        model_reset();
        IIP = 1'b0;
        #2 rst = 1'b0;
        tick(10'h080, 0, 0, 0);
        tick('0, 0, 0, 0);
        checks++; if (RPTNUM !== 4'd7 || RPTADR !== 12'o4040 || RUPTOR_ !== 1'b0) begin failures++; $display("FAIL rst_after got=%0d/%o/%b exp 7/4040/0", RPTNUM, RPTADR, RUPTOR_); end
        tick('0, 0, 0, 1);
    endtask

    task automatic test_random();
        logic [9:0] req;
        for (int c = 0; c < 1500; c++) begin
            INHINT = ($urandom_range(7) == 0);
            MNHRPT = ($urandom_range(15) == 0);
            IIP    = ($urandom_range(2) == 0);
            req    = 10'($urandom & $urandom & $urandom);
            tick(req, $urandom_range(2) == 0, $urandom_range(3) == 0, $urandom_range(63) == 0);
            checks++;
            if (PENDING !== m_pend || RPTNUM !== 4'(m_shown) || RPTADR !== addr_of(m_shown) ||
                RUPTOR_ !== (m_phase != M_ASKING) || BUSY !== (m_phase == M_TAKEN || m_phase == M_SERVICE)) begin
                failures++;
                $display("FAIL random cyc=%0d pend=%h/%h num=%0d/%0d adr=%o/%o ruptor=%b busy=%b phase=%0d",
                         c, PENDING, m_pend, RPTNUM, m_shown, RPTADR, addr_of(m_shown), RUPTOR_, BUSY, m_phase);
            end
        end
        INHINT = 0; MNHRPT = 0; IIP = 0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_inhibit();
        test_same_bit();
        test_timeout();
        test_gojam();
        test_rst_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rupt_priority.md
RUPT_PRIORITY -- requirements
Module: rupt_priority

Interface
REQ-001 Parameter NSRC, default 10, number of interrupt sources; fixed at 10 for this block.
REQ-002 Parameter RUPT_BASE, default 12'o4000, base address of the interrupt vector table.
REQ-003 CLOCK  input  1  single system clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 RUPTREQ  input  10  one-cycle request pulses; bit0=T6RUPT (highest priority), then T5, T3, T4, KEYRUPT1, KEYRUPT2, UPRUPT, DOWNRUPT, RADRUPT, bit9=HNDRUPT (lowest).
REQ-006 INHINT  input  1  software interrupt inhibit from the sequence generator.
REQ-007 MNHRPT  input  1  monitor interrupt inhibit.
REQ-008 IIP  input  1  interrupt-in-progress level from the sequence generator.
REQ-009 KRPT  input  1  one-cycle acknowledge pulse: the sequence generator has taken the presented interrupt.
REQ-010 RSM3  input  1  one-cycle resume pulse: interrupt service is complete.
REQ-011 GOJAM  input  1  one-cycle restart pulse.
REQ-012 RUPTOR_  output  1  active-low interrupt request to the sequence generator.
REQ-013 RPTADR  output  12  vector address of the selected source.
REQ-014 RPTNUM  output  4  index of the selected source, 0-9; 15 when none is selected.
REQ-015 PENDING  output  10  pending-request latches, for visibility.
REQ-016 BUSY  output  1  high in ACKD and SERVE states.

Function
REQ-017 Each RUPTREQ bit high at a clock edge sets the matching PENDING bit; latched requests are held until cleared.
REQ-018 State machine states: IDLE, REQ, ACKD, SERVE.
REQ-019 IDLE->REQ when PENDING!=0, INHINT=0, MNHRPT=0, IIP=0.
REQ-020 In REQ, selection is the lowest-index pending bit, re-evaluated every cycle; a higher-priority arrival preempts the selection before KRPT.
REQ-021 RUPTOR_=0 only in REQ; otherwise 1.
REQ-022 REQ->IDLE when INHINT or MNHRPT rises before KRPT; PENDING is unchanged.
REQ-023 REQ->ACKD on KRPT: freeze RPTNUM/RPTADR on the current selection and clear that PENDING bit at the same edge.
REQ-024 A new request on the same bit in the KRPT cycle wins over the clear; the bit stays set.
REQ-025 KRPT outside REQ is ignored.
REQ-026 ACKD->SERVE when IIP=1; ACKD->IDLE after 16 cycles without IIP (timeout); the cleared bit is not restored on timeout.
REQ-027 SERVE->IDLE on RSM3; RSM3 in any other state is ignored.
REQ-028 Nested interrupts are not permitted; no REQ entry while BUSY=1 or IIP=1.
REQ-029 RPTADR = RUPT_BASE + 4*(RPTNUM+1); e.g. T6RUPT=12'o4004 and HNDRUPT=12'o4050; 12'o0000 when RPTNUM=15.
REQ-030 RPTADR/RPTNUM are registered; they update one cycle after a selection change and hold in ACKD/SERVE.
REQ-031 GOJAM clears PENDING, forces IDLE, sets RPTNUM=15, RUPTOR_=1; RUPTREQ in the GOJAM cycle is discarded.

Reset
REQ-032 rst asynchronously forces IDLE, PENDING=0, RUPTOR_=1, RPTNUM=15, RPTADR=0, BUSY=0, timeout counter=0.
REQ-033 rst mid-handshake (REQ/ACKD/SERVE) discards all state; the first post-reset request is handled from IDLE.

Verification
REQ-034 Pulse bit4 (KEYRUPT1), inhibits low -> RUPTOR_=0 two cycles later, RPTNUM=4, RPTADR=12'o4024; KRPT -> PENDING=0, BUSY=1.
REQ-035 Pulse bits 9 and 2 in the same cycle -> RPTNUM=2 (12'o4014); KRPT, IIP, RSM3 -> then RPTNUM=9 (12'o4050) presented.
REQ-036 INHINT=1, pulse bit0 -> RUPTOR_ stays 1, PENDING=10'h001; drop INHINT -> RUPTOR_=0, RPTADR=12'o4004.
REQ-037 KRPT with same-bit request in the same cycle -> PENDING bit stays 1; after RSM3 the source is re-presented.
REQ-038 KRPT then no IIP for 16 cycles -> return to IDLE, BUSY=0, timed-out bit stays cleared.
REQ-039 GOJAM or rst during SERVE with PENDING=10'h3FF -> PENDING=0, RUPTOR_=1, RPTNUM=15.
